// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-wide data memory.
// Byte/half stores use read-modify-write; loads return lane-formatted, extended data.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [1:0]  resp_cause,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {IDLE, RD, RD_DATA, WR, RESP} state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILL   = 2'b10;
    localparam logic [1:0] CAUSE_RANGE = 2'b11;

    state_t      state;
    logic        we_p0;
    logic [2:0]  funct3_p0;
    logic [1:0]  lane_p0;
    logic [15:0] wdata_p0;
    logic [1:0]  accept_cause;

    function automatic logic [1:0] fault_cause(input logic we, input logic [2:0] f3,
                                               input logic [31:0] addr);
        logic [1:0] c;
        c = CAUSE_NONE;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (we && f3[2]))
            c = CAUSE_ILL;
        else if ((f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00))
            c = CAUSE_ALIGN;
        else if (addr >= 32'(MEM_BYTES))
            c = CAUSE_RANGE;
        return c;
    endfunction

    // Select the addressed lane and extend it; funct3[2] selects zero extension.
    function automatic logic [31:0] format_load(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'd0, b} : 32'(b);
            2'b01:   r = f3[2] ? {16'd0, h} : 32'(h);
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] wd,
                                                input logic [2:0] f3, input logic [1:0] lane);
        logic [31:0] r;
        r = word;
        if (f3[1:0] == 2'b01) begin
            if (lane[1]) r[31:16] = wd;
            else         r[15:0]  = wd;
        end else begin
            case (lane)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end
        return r;
    endfunction

    assign accept_cause     = fault_cause(req_we, req_funct3, req_addr);
    assign req_ready        = (state == IDLE) && !rst;
    assign mem_read_enable  = (state == RD) && !rst;
    assign mem_write_enable = (state == WR) && !rst;
    assign resp_valid       = (state == RESP) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            we_p0          <= 1'b0;
            funct3_p0      <= 3'd0;
            lane_p0        <= 2'd0;
            wdata_p0       <= 16'd0;
            mem_address    <= 32'd0;
            mem_write_data <= 32'd0;
            resp_rdata     <= 32'd0;
            resp_fault     <= 1'b0;
            resp_cause     <= CAUSE_NONE;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_p0       <= req_we;
                    funct3_p0   <= req_funct3;
                    lane_p0     <= req_addr[1:0];
                    wdata_p0    <= req_wdata[15:0];
                    mem_address <= {req_addr[31:2], 2'b00};
                    if (accept_cause != CAUSE_NONE) begin
                        resp_fault <= 1'b1;
                        resp_cause <= accept_cause;
                        resp_rdata <= 32'd0;
                        state      <= RESP;
                    end else if (req_we && req_funct3 == 3'b010) begin
                        mem_write_data <= req_wdata;
                        state          <= WR;
                    end else begin
                        state <= RD;
                    end
                end
                RD: state <= RD_DATA;
                // Read word is on mem_read_data this cycle.
                RD_DATA: begin
                    if (we_p0) begin
                        mem_write_data <= merge_store(mem_read_data, wdata_p0, funct3_p0, lane_p0);
                        state          <= WR;
                    end else begin
                        resp_rdata <= format_load(mem_read_data, funct3_p0, lane_p0);
                        resp_fault <= 1'b0;
                        resp_cause <= CAUSE_NONE;
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_rdata <= 32'd0;
                    resp_fault <= 1'b0;
                    resp_cause <= CAUSE_NONE;
                    state      <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Core-side initiator for the word-wide data memory (`DataMemory`). It accepts one RV32I load/store request at a time from the execute stage. It translates the request into aligned word reads and writes on the memory port, using read-modify-write for SB/SH. It returns sign- or zero-extended load data plus a fault indication.

Parameters:
- MEM_BYTES, 1024, size of the byte-addressable data memory. A request with address >= MEM_BYTES is an out-of-range fault.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit can accept; high only in IDLE with rst low.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; only the low byte/half is used for SB/SH.
- resp_valid  output  1  one-cycle pulse when the request completes; there is no backpressure.
- resp_rdata  output  32  formatted load data, held until the next response; 0 for stores and faults.
- resp_fault  output  1  request faulted; no memory access was made.
- resp_cause  output  2  01 misaligned, 10 illegal funct3, 11 out of range, 00 no fault.
- mem_address  output  32  word-aligned address {addr[31:2],2'b00}.
- mem_write_data  output  32  merged store word.
- mem_write_enable  output  1  memory writes at the rising edge where this is high.
- mem_read_enable  output  1  read request.
- mem_read_data  input  32  read data, valid the cycle after mem_read_enable.

Behaviour:
- Reset: state = IDLE. resp_rdata, resp_fault, resp_cause, mem_address and mem_write_data are 0. While rst is high, all enables, resp_valid and req_ready are forced to 0.
- Accept: a request is accepted at a rising edge with req_valid && req_ready. All req_* fields are registered at that edge; the inputs are ignored at all other times.
- Fault checks run at accept, in priority order illegal > misaligned > out of range:
  - illegal: funct3 is 011, 110 or 111, or a store uses 100/101.
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - out of range: addr >= MEM_BYTES.
- States and transitions:
  - IDLE: a faulting request goes to RESP with fault set. SW goes to WR. Loads, SB and SH go to RD.
  - RD: mem_read_enable=1, then go to RD_DATA.
  - RD_DATA: capture mem_read_data.
    - For a load, format the data into resp_rdata and go to RESP.
    - For SB/SH, merge the store data into the captured word and go to WR.
  - WR: mem_write_enable=1 with the merged/aligned data, then go to RESP.
  - RESP: resp_valid=1, then go to IDLE.
- mem_* outputs are decoded from the state register only; they never depend combinationally on req_*.
- Latency, with accept at edge T: fault resp at T+1, SW resp at T+2, loads resp at T+3, SB/SH resp at T+4 (write cycle at T+3).
- Back-to-back: the next request can be accepted in the IDLE cycle after RESP, so throughput is one request per latency+1 cycles.
- Format and merge (little-endian):
  - Byte lane = addr[1:0]; half lane = addr[1].
  - B/H sign-extend bit 7/15 of the selected lane; BU/HU zero-extend.
  - SB replaces byte lane addr[1:0] with wdata[7:0]. SH replaces the half selected by addr[1] with wdata[15:0]. All other bytes are preserved from the read.
- Reset mid-operation: the FSM returns to IDLE at the next edge and the request is abandoned. A WR cycle coinciding with rst high performs no write, and no resp_valid is issued.
- req_valid held high while busy is not accepted, and no state is corrupted.

Test Plan:
1. SW addr 0x4, wdata 0xDEADBEEF, accept at T -> at T+1 mem_write_enable=1, mem_address=0x4, mem_write_data=0xDEADBEEF; at T+2 resp_valid=1 with resp_fault=0.
2. LW 0x4 after test 1 -> mem_read_enable at T+1; at T+3 resp_rdata=0xDEADBEEF.
3. Word 0x8=0xCAFEBABE -> LB 0x9 returns 0xFFFFFFBA, LBU 0x9 returns 0x000000BA, LH 0xA returns 0xFFFFCAFE, LHU 0xA returns 0x0000CAFE.
4. SB 0x9, wdata 0x11, over 0xCAFEBABE -> read at T+1, write 0xCAFE11BE at T+3, resp at T+4; a following SH 0xA 0x1234 makes LW 0x8 return 0x123411BE.
5. Fault cases, each giving resp at T+1 with no mem enables:
   - LW 0x6 -> cause 01.
   - funct3 011 -> cause 10.
   - SB with funct3 100 -> cause 10.
   - LW 0x400 -> cause 11.
   - LH 0x401 -> cause 01.
6. rst high during RD_DATA of an SB -> no mem_write_enable and no resp_valid; req_ready=1 the first cycle after rst falls; word contents unchanged.
